// File: rtl/des_feistel_f_pipe_if.sv
// Handshake bundle for the pipelined DES round function:
// upstream R/K with valid/ready, downstream f with valid/ready.
interface des_feistel_f_pipe_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] r_in;
   logic [47:0] subkey;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] f_out;

   modport master (
      output in_valid, r_in, subkey, out_ready,
      input  in_ready, out_valid, f_out
   );

   modport slave (
      input  in_valid, r_in, subkey, out_ready,
      output in_ready, out_valid, f_out
   );
endinterface

// File: rtl/des_feistel_f_pipe.sv
// Pipelined DES round function f(R,K) = P(S(E(R) ^ K)).
// Stage 1 registers E(R)^K; stage 2 applies S-boxes and P, optionally registered.
module des_feistel_f_pipe #(
   parameter int unsigned SBOX_REG = 1
) (
   input logic             clk,
   input logic             rst,
   des_feistel_f_pipe_if.slave bus
);

   // S-box tables, one row of 16 nibbles per line, entry 0 in the top nibble.
   localparam logic [255:0] SBOX [8] = '{
      {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
       64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
      {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
       64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
      {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
       64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
      {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
       64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
      {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
       64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
      {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
       64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
      {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
       64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
      {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
       64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
   };

   localparam int unsigned PERM [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,
       1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,
      19, 13, 30,  6, 22, 11,  4, 25
   };

   logic        accept;
   logic        s1_valid;
   logic        s1_take;
   logic [47:0] s1_data;
   logic [47:0] e_val;
   logic [31:0] s_val;
   logic [31:0] f_val;

   // E: output DES bit 6j+k+1 takes input DES bit ((4j+k-1) mod 32)+1.
   always_comb begin
      e_val = '0;
      for (int unsigned j = 0; j < 8; j++) begin
         for (int unsigned k = 0; k < 6; k++) begin
            e_val[47 - 6*j - k] = bus.r_in[31 - ((4*j + k + 31) % 32)];
         end
      end
   end

   always_comb begin : sbox_stage
      logic [5:0] addr;
      logic [5:0] idx;
      addr  = '0;
      idx   = '0;
      s_val = '0;
      for (int unsigned j = 0; j < 8; j++) begin
         addr = s1_data[47 - 6*j -: 6];
         idx  = {addr[5], addr[0], addr[4:1]};
         // entry idx sits at bit 4*(63-idx), i.e. {~idx,2'b00}
         s_val[31 - 4*j -: 4] = SBOX[j][{~idx, 2'b00} +: 4];
      end
   end

   always_comb begin
      f_val = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         f_val[31 - i] = s_val[32 - PERM[i]];
      end
   end

   assign accept       = bus.in_valid & bus.in_ready;
   assign bus.in_ready = ~s1_valid | s1_take;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= accept | (s1_valid & ~s1_take);
         if (accept) begin
            s1_data <= e_val ^ bus.subkey;
         end
      end
   end

   generate
      if (SBOX_REG != 0) begin : g_reg
         logic        s2_valid;
         logic        s2_fire;
         logic [31:0] f_reg;

         assign s2_fire = s1_valid & (~s2_valid | bus.out_ready);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s2_valid <= 1'b0;
               f_reg    <= '0;
            end else if (s2_fire) begin
               s2_valid <= 1'b1;
               f_reg    <= f_val;
            end else if (bus.out_ready) begin
               s2_valid <= 1'b0;
            end
         end

         assign s1_take       = s2_fire;
         assign bus.out_valid = s2_valid;
         assign bus.f_out     = f_reg;
      end else begin : g_comb
         assign s1_take       = s1_valid & bus.out_ready;
         assign bus.out_valid = s1_valid;
         assign bus.f_out     = f_val;
      end
   endgenerate

endmodule
